// File: rtl/hssi_csr_pkg.sv
// Shared HSSI CSR types: synchronized lane stats and the lane reset-sequencer state codes.
// The state codes double as the o_err_stage encoding reported to the CSR block.
package hssi_csr_pkg;

    localparam int unsigned HSSI_RST_STAGE_W = 3;

    typedef enum logic [HSSI_RST_STAGE_W-1:0] {
        RstIdle    = 3'd0,
        RstAssert  = 3'd1,
        RstRelAna  = 3'd2,
        RstRelTxd  = 3'd3,
        RstWaitCdr = 3'd4,
        RstRelRxd  = 3'd5,
        RstErrHold = 3'd6
    } hssi_rst_state_e;

    typedef struct packed {
        logic tx_ready;
        logic rx_ready;
        logic rx_is_lockedtodata;
        logic tx_cal_busy;
        logic rx_cal_busy;
        logic tx_analogreset_stat;
        logic tx_digitalreset_stat;
        logic rx_analogreset_stat;
        logic rx_digitalreset_stat;
    } hssi_stats_struct_t;

    // Reset request pattern per state, ordered {tx_ana, tx_dig, rx_ana, rx_dig}.
    function automatic logic [3:0] rst_out_mask(hssi_rst_state_e st);
        logic [3:0] m;
        unique case (st)
            RstIdle:               m = 4'b0000;
            RstRelAna:             m = 4'b0101;
            RstRelTxd, RstWaitCdr: m = 4'b0001;
            RstRelRxd:             m = 4'b0000;
            default:               m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hssi_lane_rst_fsm.sv
// One-lane transceiver reset sequencer with hold/timeout counters and sticky error.
// Optional saturating debug counters when HSSI_RST_DBG_CNT_EN is defined.
module hssi_lane_rst_fsm
    import hssi_csr_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rst_req,
    input  logic                        i_err_clr,
    input  hssi_stats_struct_t          i_stats,
    output logic                        o_tx_analogreset,
    output logic                        o_tx_digitalreset,
    output logic                        o_rx_analogreset,
    output logic                        o_rx_digitalreset,
    output logic                        o_busy,
    output logic                        o_done,
`ifdef HSSI_RST_DBG_CNT_EN
    output logic [15:0]                 o_seq_done_cnt,
    output logic [15:0]                 o_seq_tmo_cnt,
`endif
    output logic                        o_timeout_err,
    output logic [HSSI_RST_STAGE_W-1:0] o_err_stage
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    hssi_rst_state_e             r_state;
    hssi_rst_state_e             w_state_nxt;
    logic [HOLD_W-1:0]           r_hold_cnt;
    logic [TMO_W-1:0]            r_tmo_cnt;
    logic [3:0]                  r_rst_out;
    logic                        r_done;
    logic                        r_tmo_err;
    logic [HSSI_RST_STAGE_W-1:0] r_err_stage;
    logic                        w_hold_done;
    logic                        w_in_seq;
    logic                        w_exit;
    logic                        w_tmo_active;
    logic                        w_tmo_hit;
    logic                        w_done_evt;

    always_comb begin
        w_hold_done = (r_hold_cnt == '0);
        w_in_seq    = (r_state != RstIdle) && (r_state != RstErrHold);
        unique case (r_state)
            RstAssert:  w_exit = w_hold_done &&
                                 i_stats.tx_analogreset_stat && i_stats.rx_analogreset_stat &&
                                 i_stats.tx_digitalreset_stat && i_stats.rx_digitalreset_stat;
            RstRelAna:  w_exit = !i_stats.tx_analogreset_stat && !i_stats.rx_analogreset_stat &&
                                 !i_stats.tx_cal_busy && !i_stats.rx_cal_busy;
            RstRelTxd:  w_exit = !i_stats.tx_digitalreset_stat && i_stats.tx_ready;
            RstWaitCdr: w_exit = i_stats.rx_is_lockedtodata;
            RstRelRxd:  w_exit = !i_stats.rx_digitalreset_stat && i_stats.rx_ready;
            default:    w_exit = 1'b0;
        endcase
        // The ASSERT timeout window only opens once the hold time has elapsed.
        w_tmo_active = w_in_seq && ((r_state != RstAssert) || w_hold_done);
        w_tmo_hit    = w_tmo_active && !w_exit && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC));
        w_done_evt   = (r_state == RstRelRxd) && w_exit;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RstIdle, RstErrHold: if (i_rst_req) w_state_nxt = RstAssert;
            RstAssert:           if (w_exit) w_state_nxt = RstRelAna;
            RstRelAna:           if (w_exit) w_state_nxt = RstRelTxd;
            RstRelTxd:           if (w_exit) w_state_nxt = RstWaitCdr;
            RstWaitCdr:          if (w_exit) w_state_nxt = RstRelRxd;
            RstRelRxd:           if (w_exit) w_state_nxt = RstIdle;
            default:             w_state_nxt = RstErrHold;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt = RstErrHold;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RstErrHold;
            r_hold_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_rst_out   <= 4'b1111;
            r_done      <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_err_stage <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_out <= rst_out_mask(r_state);
            r_done    <= w_done_evt;
            if (w_state_nxt == RstAssert && r_state != RstAssert) begin
                r_hold_cnt <= HOLD_W'(HOLD_CYC);
            end else if (!w_hold_done) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_active && r_tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_hit) begin
                r_tmo_err   <= 1'b1;
                r_err_stage <= r_state;
            end else if (i_err_clr) begin
                r_tmo_err   <= 1'b0;
                r_err_stage <= '0;
            end
        end
    end

`ifdef HSSI_RST_DBG_CNT_EN
    logic [15:0] r_seq_done_cnt;
    logic [15:0] r_seq_tmo_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seq_done_cnt <= '0;
            r_seq_tmo_cnt  <= '0;
        end else begin
            if (w_done_evt && r_seq_done_cnt != 16'hFFFF) begin
                r_seq_done_cnt <= r_seq_done_cnt + 16'd1;
            end
            if (w_tmo_hit && r_seq_tmo_cnt != 16'hFFFF) begin
                r_seq_tmo_cnt <= r_seq_tmo_cnt + 16'd1;
            end
        end
    end

    assign o_seq_done_cnt = r_seq_done_cnt;
    assign o_seq_tmo_cnt  = r_seq_tmo_cnt;
`endif

    assign o_tx_analogreset  = r_rst_out[3];
    assign o_tx_digitalreset = r_rst_out[2];
    assign o_rx_analogreset  = r_rst_out[1];
    assign o_rx_digitalreset = r_rst_out[0];
    assign o_busy            = w_in_seq;
    assign o_done            = r_done;
    assign o_timeout_err     = r_tmo_err;
    assign o_err_stage       = r_err_stage;

endmodule

// File: rtl/hssi_lane_rst_ctrl.sv
// Per-lane HSSI transceiver reset sequencer array in the FME clock domain.
// Define HSSI_RST_DBG_CNT_EN to add per-lane done/timeout debug counters.
module hssi_lane_rst_ctrl
    import hssi_csr_pkg::*;
#(
    parameter int unsigned NUM_LN      = 4,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                                 i_fme_clk,
    input  logic                                 i_fme_rst,
    input  logic [NUM_LN-1:0]                    i_rst_req,
    input  logic [NUM_LN-1:0]                    i_err_clr,
    input  hssi_stats_struct_t                   i_hssi_stats_sync [NUM_LN],
    output logic [NUM_LN-1:0]                    o_tx_analogreset,
    output logic [NUM_LN-1:0]                    o_tx_digitalreset,
    output logic [NUM_LN-1:0]                    o_rx_analogreset,
    output logic [NUM_LN-1:0]                    o_rx_digitalreset,
    output logic [NUM_LN-1:0]                    o_busy,
    output logic [NUM_LN-1:0]                    o_done,
`ifdef HSSI_RST_DBG_CNT_EN
    output logic [15:0]                          o_seq_done_cnt [NUM_LN],
    output logic [15:0]                          o_seq_tmo_cnt [NUM_LN],
`endif
    output logic [NUM_LN-1:0]                    o_timeout_err,
    output logic [HSSI_RST_STAGE_W*NUM_LN-1:0]   o_err_stage
);

    for (genvar gi = 0; gi < NUM_LN; gi++) begin : g_lane
        hssi_lane_rst_fsm #(
            .HOLD_CYC    (HOLD_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_fsm (
            .i_clk             (i_fme_clk),
            .i_rst             (i_fme_rst),
            .i_rst_req         (i_rst_req[gi]),
            .i_err_clr         (i_err_clr[gi]),
            .i_stats           (i_hssi_stats_sync[gi]),
            .o_tx_analogreset  (o_tx_analogreset[gi]),
            .o_tx_digitalreset (o_tx_digitalreset[gi]),
            .o_rx_analogreset  (o_rx_analogreset[gi]),
            .o_rx_digitalreset (o_rx_digitalreset[gi]),
            .o_busy            (o_busy[gi]),
            .o_done            (o_done[gi]),
`ifdef HSSI_RST_DBG_CNT_EN
            .o_seq_done_cnt    (o_seq_done_cnt[gi]),
            .o_seq_tmo_cnt     (o_seq_tmo_cnt[gi]),
`endif
            .o_timeout_err     (o_timeout_err[gi]),
            .o_err_stage       (o_err_stage[gi*HSSI_RST_STAGE_W +: HSSI_RST_STAGE_W])
        );
    end

endmodule

// File: tb/tb_hssi_lane_rst_ctrl.sv
// Randomized bench for hssi_lane_rst_ctrl against a stage/elapsed-time reference model.
// Debug-counter checks are compiled in when HSSI_RST_DBG_CNT_EN is defined.
module tb_hssi_lane_rst_ctrl;
    import hssi_csr_pkg::*;

    localparam int NL   = 4;
    localparam int HOLD = 16;
    localparam int TMO  = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NL-1:0]      req = '0;
    logic [NL-1:0]      clr = '0;
    hssi_stats_struct_t stats [NL];
    logic [NL-1:0]      txa, txd, rxa, rxd, busy, done, terr;
    logic [3*NL-1:0]    estg;
    logic [NL-1:0]      stuck_cal = '0;
    logic [NL-1:0]      lock_en = '1;
`ifdef HSSI_RST_DBG_CNT_EN
    logic [15:0]        dcnt [NL];
    logic [15:0]        tcnt [NL];
`endif

    hssi_lane_rst_ctrl #(
        .NUM_LN      (NL),
        .HOLD_CYC    (HOLD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_fme_clk         (clk),
        .i_fme_rst         (rst),
        .i_rst_req         (req),
        .i_err_clr         (clr),
        .i_hssi_stats_sync (stats),
        .o_tx_analogreset  (txa),
        .o_tx_digitalreset (txd),
        .o_rx_analogreset  (rxa),
        .o_rx_digitalreset (rxd),
        .o_busy            (busy),
        .o_done            (done),
`ifdef HSSI_RST_DBG_CNT_EN
        .o_seq_done_cnt    (dcnt),
        .o_seq_tmo_cnt     (tcnt),
`endif
        .o_timeout_err     (terr),
        .o_err_stage       (estg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dut_done_cnt [NL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: lane stage plus cycles elapsed since entering it.
    int         m_stage [NL];
    int         m_age [NL];
    logic       m_flag [NL];
    int         m_est [NL];
    logic [3:0] m_rst [NL];
    logic       m_done [NL];
    int         m_dcnt [NL];
    int         m_tcnt [NL];

    function automatic logic [3:0] exp_mask(int st);
        case (st)
            0, 5:    return 4'b0000;
            2:       return 4'b0101;
            3, 4:    return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic bit exit_ok(int st, int age, hssi_stats_struct_t s);
        case (st)
            1: return age >= HOLD && s.tx_analogreset_stat && s.rx_analogreset_stat &&
                      s.tx_digitalreset_stat && s.rx_digitalreset_stat;
            2: return !s.tx_analogreset_stat && !s.rx_analogreset_stat &&
                      !s.tx_cal_busy && !s.rx_cal_busy;
            3: return !s.tx_digitalreset_stat && s.tx_ready;
            4: return s.rx_is_lockedtodata;
            5: return !s.rx_digitalreset_stat && s.rx_ready;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int st, nst, waited;
        bit ex, to;
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                m_stage[l] = 6; m_age[l] = 0; m_flag[l] = 1'b0; m_est[l] = 0;
                m_rst[l] = 4'hF; m_done[l] = 1'b0; m_dcnt[l] = 0; m_tcnt[l] = 0;
            end else begin
                st     = m_stage[l];
                ex     = (st >= 1 && st <= 5) && exit_ok(st, m_age[l], stats[l]);
                waited = (st == 1) ? m_age[l] - HOLD : m_age[l];
                to     = (st >= 1 && st <= 5) && !ex && waited >= TMO;
                nst    = st;
                if ((st == 0 || st == 6) && req[l]) nst = 1;
                else if (ex) nst = (st == 5) ? 0 : st + 1;
                else if (to) nst = 6;
                m_done[l] = ex && st == 5;
                if (m_done[l] && m_dcnt[l] < 65535) m_dcnt[l]++;
                if (to && m_tcnt[l] < 65535) m_tcnt[l]++;
                if (to) begin
                    m_flag[l] = 1'b1; m_est[l] = st;
                end else if (clr[l]) begin
                    m_flag[l] = 1'b0; m_est[l] = 0;
                end
                m_rst[l]   = exp_mask(st);
                m_age[l]   = (nst != st) ? 0 : m_age[l] + 1;
                m_stage[l] = nst;
            end
        end
    end

    // Compare every lane every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("lane%0d", l),
                    {22'd0, txa[l], txd[l], rxa[l], rxd[l], busy[l], done[l], terr[l],
                     estg[3*l +: 3]},
                    {22'd0, m_rst[l], 1'(m_stage[l] >= 1 && m_stage[l] <= 5), m_done[l],
                     m_flag[l], 3'(m_est[l])});
`ifdef HSSI_RST_DBG_CNT_EN
                chk($sformatf("dbg%0d", l), {dcnt[l], tcnt[l]},
                    {16'(m_dcnt[l]), 16'(m_tcnt[l])});
`endif
                if (done[l]) dut_done_cnt[l]++;
            end
        end
    end

    // Transceiver stand-in: status bits follow the requests with random lag.
    always @(negedge clk) begin
        hssi_stats_struct_t s;
        for (int l = 0; l < NL; l++) begin
            s = stats[l];
            if ($urandom_range(1, 0) == 1) s.tx_analogreset_stat  = txa[l];
            if ($urandom_range(1, 0) == 1) s.tx_digitalreset_stat = txd[l];
            if ($urandom_range(1, 0) == 1) s.rx_analogreset_stat  = rxa[l];
            if ($urandom_range(1, 0) == 1) s.rx_digitalreset_stat = rxd[l];
            s.tx_cal_busy = stuck_cal[l] | (s.tx_analogreset_stat & ($urandom_range(3, 0) == 0));
            s.rx_cal_busy = s.rx_analogreset_stat & ($urandom_range(3, 0) == 0);
            s.rx_is_lockedtodata = !s.rx_analogreset_stat && lock_en[l] &&
                                   ($urandom_range(3, 0) != 0);
            s.tx_ready = !s.tx_digitalreset_stat;
            s.rx_ready = !s.rx_digitalreset_stat && s.rx_is_lockedtodata;
            stats[l] = s;
        end
    end

    task automatic pulse_req(input int l);
        @(negedge clk); req[l] = 1'b1;
        @(negedge clk); req[l] = 1'b0;
    endtask

    task automatic wait_done(input int l, input int budget, input string name);
        int n = 0;
        while (!done[l] && n < budget) begin
            @(negedge clk); n++;
        end
        chk(name, 32'(done[l]), 32'd1);
    endtask

    initial begin
        int n;
        for (int l = 0; l < NL; l++) begin
            stats[l] = '0; dut_done_cnt[l] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_outs", {txa, txd, rxa, rxd}, 32'hFFFF);
        chk("rst_busy_done", {busy, done}, 32'h0);
        chk("rst_err", {terr, estg}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_after_rst", {txa, rxd}, 32'hFF);

        // Power-up sequence on lane 0.
        pulse_req(0);
        wait_done(0, HOLD + 200, "l0_done");
        repeat (5) @(negedge clk);
        chk("l0_rst_off", {txa[0], txd[0], rxa[0], rxd[0]}, 32'h0);
        chk("l0_no_err", 32'(terr[0]), 32'h0);
        chk("l0_done_once", 32'(dut_done_cnt[0]), 32'd1);

        // Stuck calibration on lane 1 times out in REL_ANA.
        stuck_cal[1] = 1'b1;
        pulse_req(1);
        n = 0;
        while (!terr[1] && n < TMO + HOLD + 300) begin
            @(negedge clk); n++;
        end
        chk("l1_tmo", 32'(terr[1]), 32'd1);
        chk("l1_stage", 32'(estg[5:3]), 32'd2);
        repeat (2) @(negedge clk);
        chk("l1_rst_held", {txa[1], txd[1], rxa[1], rxd[1]}, 32'hF);
        chk("l0_unaffected", {txa[0], txd[0], rxa[0], rxd[0], terr[0]}, 32'h0);

        // Error recovery on lane 1.
        stuck_cal[1] = 1'b0;
        @(negedge clk); clr[1] = 1'b1;
        @(negedge clk); clr[1] = 1'b0;
        chk("l1_clr", {terr[1], estg[5:3]}, 32'h0);
        chk("l1_clr_keeps_rst", {txa[1], rxd[1]}, 32'h3);
        pulse_req(1);
        wait_done(1, HOLD + 200, "l1_done");
        chk("l1_flag_clear", 32'(terr[1]), 32'h0);

        // Second request mid-sequence on lane 2 is ignored.
        pulse_req(2);
        repeat (4) @(negedge clk);
        pulse_req(2);
        wait_done(2, HOLD + 200, "l2_done");
        repeat (40) @(negedge clk);
        chk("l2_done_once", 32'(dut_done_cnt[2]), 32'd1);
`ifdef HSSI_RST_DBG_CNT_EN
        chk("dbg_done_total", 32'(dcnt[0] + dcnt[1] + dcnt[2]), 32'd3);
        chk("dbg_tmo_l1", 32'(tcnt[1]), 32'd1);
`endif

        // Random requests, clears and lock drop-outs on all lanes.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                req[l] = ($urandom_range(15, 0) == 0);
                clr[l] = ($urandom_range(15, 0) == 0);
                if ($urandom_range(199, 0) == 0) lock_en[l] = ~lock_en[l];
            end
        end
        req = '0; clr = '0; lock_en = '1;
        repeat (200) @(negedge clk);

`ifdef HSSI_RST_DBG_CNT_EN
        // Saturation: a preloaded all-ones counter must not wrap.
        force dut.g_lane[0].u_fsm.r_seq_done_cnt = 16'hFFFF;
        m_dcnt[0] = 65535;
        @(negedge clk);
        release dut.g_lane[0].u_fsm.r_seq_done_cnt;
        pulse_req(0);
        wait_done(0, HOLD + 200, "l0_sat_done");
        @(negedge clk);
        chk("dbg_sat", 32'(dcnt[0]), 32'hFFFF);
`endif

        // Asynchronous reset while lane 3 sits in REL_TXD.
        pulse_req(3);
        n = 0;
        while (m_stage[3] != 3 && n < HOLD + 200) begin
            @(negedge clk); n++;
        end
        chk("l3_reach_txd", 32'(m_stage[3]), 32'd3);
        chk("l3_busy_pre", 32'(busy[3]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {txa[3], txd[3], rxa[3], rxd[3]}, 32'hF);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_err", {terr, estg}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
